// File: rtl/regfile_pkg.sv
// Shared widths and the write-back entry type for the register-file write queue.
package regfile_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

    // r0 is hardwired to zero; writes to it are dropped and it never forwards.
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of write-back entries; exposes every slot in age order
// (index 0 = oldest) so the parent can search for the newest matching address.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  wb_entry_t        entry_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output wb_entry_t        ordered_o [DEPTH],
    output logic [CNT_W-1:0] count_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy next-state; clear wins over push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PTR_W'(1);
            if (pop_i)  head_d = head_q + PTR_W'(1);
            if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
            else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer/occupancy state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; slots beyond count are stale and masked by the reader.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !clear_i && push_i) begin
            mem_q[tail_q] <= entry_i;
        end
    end

    // Power-of-two depth lets the pointer sum wrap naturally.
    for (genvar g = 0; g < DEPTH; g++) begin : g_view
        assign ordered_o[g] = mem_q[head_q + PTR_W'(g)];
    end

    assign count_o = count_q;

endmodule

// File: rtl/regfile_write_queue.sv
// Write-back queue in front of the register array: buffers execute results,
// drains one per cycle as a one-hot write enable plus shared data, and
// forwards pending values to two operand read ports.
module regfile_write_queue
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_valid,
    output logic                wb_ready,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                hold,
    input  logic                flush,
    output logic [NUM_REGS-1:0] write_enable,
    output logic [DATA_W-1:0]   data_in,
    input  logic [ADDR_W-1:0]   fwd_addr_a,
    input  logic [ADDR_W-1:0]   fwd_addr_b,
    output logic                fwd_hit_a,
    output logic                fwd_hit_b,
    output logic [DATA_W-1:0]   fwd_data_a,
    output logic [DATA_W-1:0]   fwd_data_b,
    output logic [CNT_W-1:0]    pending,
    output logic                idle
);

    wb_entry_t           fifo_view [DEPTH];
    logic [CNT_W-1:0]    count;
    logic                accept, push, pop;
    logic [NUM_REGS-1:0] we_q, we_d;
    logic [DATA_W-1:0]   data_q, data_d;

    // Full blocks acceptance even when a pop happens in the same cycle.
    assign wb_ready = rst && !flush && (count < CNT_W'(DEPTH));
    assign accept   = wb_valid && wb_ready;
    assign push     = accept && (wb_addr != ZERO_REG);
    assign pop      = rst && !hold && !flush && (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .push_i    (push),
        .entry_i   ('{addr: wb_addr, data: wb_data}),
        .pop_i     (pop),
        .clear_i   (flush),
        .ordered_o (fifo_view),
        .count_o   (count)
    );

    // Output stage next-state: decode the popped head, otherwise idle the enables.
    always_comb begin
        we_d   = '0;
        data_d = data_q;
        if (pop) begin
            we_d   = NUM_REGS'(1) << fifo_view[0].addr;
            data_d = fifo_view[0].data;
        end
    end

    // Output stage register driving the array.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q   <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            data_q <= data_d;
        end
    end

    // Output stage is older than any queued entry, so it is checked first and
    // queued matches (oldest to newest) overwrite it.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] addr);
        logic [DATA_W:0] r;
        r = '0;
        if (addr != ZERO_REG) begin
            if (we_q[addr]) r = {1'b1, data_q};
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((CNT_W'(i) < count) && (fifo_view[i].addr == addr))
                    r = {1'b1, fifo_view[i].data};
            end
        end
        return r;
    endfunction

    // Two independent forwarding comparators.
    always_comb begin
        {fwd_hit_a, fwd_data_a} = fwd_lookup(fwd_addr_a);
        {fwd_hit_b, fwd_data_b} = fwd_lookup(fwd_addr_b);
    end

    assign write_enable = we_q;
    assign data_in      = data_q;
    assign pending      = count;
    assign idle         = (count == '0) && (we_q == '0);

endmodule
